// File: rtl/acc_wmst_ctrl_pkg.sv
// Shared definitions for the conv accelerator result-path AXI4 write master.
// Contents: AXI encodings, the 4KB AXI address boundary, and the controller
// state enum used by acc_wmst_ctrl.
package acc_wmst_ctrl_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_BOUNDARY   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } wmst_state_e;

endpackage

// File: rtl/acc_wmst_ctrl_burst_gen.sv
// Burst address / remaining-word tracker for acc_wmst_ctrl.
// Holds the address of the next burst and the number of words still to be
// written, and presents the size of the next burst.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  capture load_addr / load_words (transfer start)
//   load_addr, load_words first burst address and total word count
//   advance               current burst finished: step address, consume words
//   burst_addr            address of the current burst
//   burst_beats           beats in the current burst (1..BURST_LEN)
//   last_burst            current burst consumes every remaining word
// Build option: ACC_WMST_4K_SPLIT_EN additionally clips each burst so it
// never crosses a 4KB boundary.
module acc_wmst_ctrl_burst_gen
  import acc_wmst_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 32,
  parameter int BURST_LEN  = 16,
  parameter int WORD_SHIFT = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [LEN_WIDTH-1:0]  load_words,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [8:0]            burst_beats,
  output logic                  last_burst
);

  localparam logic [LEN_WIDTH-1:0] BURST_LEN_W = LEN_WIDTH'(BURST_LEN);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  beats_w;
`ifdef ACC_WMST_4K_SPLIT_EN
  logic [12:0]           room_w;
`endif

  // Burst size is derived from registered state only, so it stays stable
  // from the AW handshake through the final W beat of the burst.
  always_comb begin
    beats_w = (rem_q < BURST_LEN_W) ? rem_q : BURST_LEN_W;
`ifdef ACC_WMST_4K_SPLIT_EN
    room_w = (13'(AXI_BOUNDARY) - {1'b0, addr_q[11:0]}) >> WORD_SHIFT;
    if (LEN_WIDTH'(room_w) < beats_w) begin
      beats_w = LEN_WIDTH'(room_w);
    end
`endif
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr;
      rem_d  = load_words;
    end else if (advance) begin
      addr_d = addr_q + (ADDR_WIDTH'(beats_w) << WORD_SHIFT);
      rem_d  = rem_q - beats_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign burst_addr  = addr_q;
  assign burst_beats = 9'(beats_w);
  assign last_burst  = (rem_q == beats_w);

endmodule

// File: rtl/acc_wmst_ctrl.sv
// AXI4 write master for the conv accelerator result path. Writes the engine's
// output word stream to DDR as INCR bursts starting at base_addr.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr, xfer_bytes  transfer request (sampled on start)
//   s_tvalid/s_tready/s_tdata  result word stream in
//   m_aw*                      AXI write address channel
//   m_w*                       AXI write data channel (data passes straight through)
//   m_bvalid/m_bresp/m_bready  AXI write response channel (bready tied high)
//   wmst_done                  level, all beats sent and all B received
//   wmst_busy                  transfer in progress
//   wmst_err                   sticky, some B response was not OKAY
// Build option: ACC_WMST_4K_SPLIT_EN enables 4KB-boundary burst splitting
// (handled in acc_wmst_ctrl_burst_gen).
module acc_wmst_ctrl
  import acc_wmst_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 512,
  parameter int ADDR_WIDTH   = 64,
  parameter int BURST_LEN    = 16,
  parameter int MAX_OUTSTAND = 4,
  parameter int LEN_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [LEN_WIDTH-1:0]    xfer_bytes,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  input  logic [1:0]              m_bresp,
  output logic                    m_bready,
  output logic                    wmst_done,
  output logic                    wmst_busy,
  output logic                    wmst_err
);

  localparam int WORD_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int OUT_W      = $clog2(MAX_OUTSTAND) + 1;

  wmst_state_e           state_q, state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [OUT_W-1:0]      outst_q, outst_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic [LEN_WIDTH-1:0]  start_words;
  logic                  start_ok;
  logic                  aw_fire, w_fire, b_fire;
  logic                  last_beat, advance, last_burst;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [8:0]            burst_beats;

  assign start_words = xfer_bytes >> WORD_SHIFT;
  assign start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // AW is only offered while the response window has room; outstanding can
  // only shrink while waiting here, so awvalid never drops before awready.
  assign m_awvalid = (state_q == ST_ADDR) && (outst_q < OUT_W'(MAX_OUTSTAND));
  assign aw_fire   = m_awvalid && m_awready;

  assign m_wvalid  = (state_q == ST_DATA) && s_tvalid;
  assign s_tready  = (state_q == ST_DATA) && m_wready;
  assign w_fire    = m_wvalid && m_wready;
  assign last_beat = ({1'b0, beat_cnt_q} == (burst_beats - 9'd1));
  assign m_wlast   = (state_q == ST_DATA) && last_beat;
  assign advance   = w_fire && last_beat;

  // A stray B with nothing outstanding is dropped rather than underflowing.
  assign b_fire    = m_bvalid && (outst_q != '0);

  acc_wmst_ctrl_burst_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .BURST_LEN  (BURST_LEN),
    .WORD_SHIFT (WORD_SHIFT)
  ) u_burst_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (start_ok),
    .load_addr   (base_addr),
    .load_words  (start_words),
    .advance     (advance),
    .burst_addr  (burst_addr),
    .burst_beats (burst_beats),
    .last_burst  (last_burst)
  );

  // Next-state logic. A new start is taken in IDLE or DONE; in DONE it wins
  // over the normal DONE->IDLE step so wmst_done is cleared, not set.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    outst_d    = outst_q;
    done_d     = done_q;
    busy_d     = busy_q;
    err_d      = err_q;

    if (aw_fire && !b_fire) begin
      outst_d = outst_q + OUT_W'(1);
    end else if (!aw_fire && b_fire) begin
      outst_d = outst_q - OUT_W'(1);
    end

    if (busy_q && b_fire && (m_bresp != AXI_RESP_OKAY)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (start_words == '0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_fire) begin
          beat_cnt_d = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_fire) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = last_burst ? ST_RESP : ST_ADDR;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        if (outst_q == '0) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= '0;
      outst_q    <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      outst_q    <= outst_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign m_awaddr  = burst_addr;
  assign m_awlen   = 8'(burst_beats - 9'd1);
  assign m_awsize  = 3'(WORD_SHIFT);
  assign m_awburst = AXI_BURST_INCR;
  assign m_wdata   = s_tdata;
  assign m_wstrb   = '1;
  assign m_bready  = 1'b1;
  assign wmst_done = done_q;
  assign wmst_busy = busy_q;
  assign wmst_err  = err_q;

endmodule

// File: tb/tb_acc_wmst_ctrl.sv
// Scoreboard bench for acc_wmst_ctrl: expected AW and W beats are queued when
// a transfer is requested; a monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_acc_wmst_ctrl;
  import acc_wmst_ctrl_pkg::*;

  localparam int DW = 512;
  localparam int AW = 64;
  localparam int LW = 32;

  typedef logic [DW-1:0] word_t;
  typedef struct packed { logic [AW-1:0] addr; logic [7:0] len; } aw_t;
  typedef struct packed { logic [DW-1:0] data; logic last; } w_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [LW-1:0]   xfer_bytes;
  logic            s_tvalid, s_tready;
  logic [DW-1:0]   s_tdata;
  logic            m_awvalid, m_awready;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst;
  logic            m_wvalid, m_wready, m_wlast;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_bvalid, m_bready;
  logic [1:0]      m_bresp;
  logic            wmst_done, wmst_busy, wmst_err;

  int    total = 0;
  int    bad   = 0;
  aw_t   exp_aw[$];
  w_t    exp_w[$];
  int    aw_cnt, w_cnt, wlast_cnt, b_cnt;
  int    src_gen, src_words, src_tid, err_burst;
  logic  b_hold;

  always #5 clk = ~clk;

  acc_wmst_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(16), .MAX_OUTSTAND(4), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .xfer_bytes(xfer_bytes),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .wmst_done(wmst_done), .wmst_busy(wmst_busy), .wmst_err(wmst_err)
  );

  function automatic word_t mk_word(input int tid, input int idx);
    logic [31:0] w;
    w = {tid[15:0], idx[15:0]};
    return {16{w}};
  endfunction

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic pushBurst(input logic [AW-1:0] addr, input int len, input int tid, input int first);
    aw_t a;
    w_t  w;
    a.addr = addr;
    a.len  = 8'(len);
    exp_aw.push_back(a);
    for (int i = 0; i <= len; i++) begin
      w.data = mk_word(tid, first + i);
      w.last = (i == len);
      exp_w.push_back(w);
    end
  endtask

  task automatic flushScoreboard();
    exp_aw.delete();
    exp_w.delete();
    aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; b_cnt = 0;
  endtask

  // Called at posedge+1; the start pulse is sampled by the following edge.
  task automatic applyStimulus(input int tid, input logic [AW-1:0] base, input logic [LW-1:0] bytes,
                               input int nwords);
    src_tid    = tid;
    src_words  = nwords;
    src_gen    = src_gen + 1;
    base_addr  = base;
    xfer_bytes = bytes;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n;
    n = 0;
    while (!wmst_done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!wmst_done) begin
      bad++;
      $display("[TB] FAIL %s_timeout: wmst_done still %0b after %0d cycles, want 1", name, wmst_done, budget);
    end
  endtask

  task automatic checkEnd(input string name, input logic err_exp);
    checkOutput({name, "_aw_left"}, word_t'(exp_aw.size()), word_t'(0));
    checkOutput({name, "_w_left"},  word_t'(exp_w.size()),  word_t'(0));
    checkOutput({name, "_busy"},    word_t'(wmst_busy),     word_t'(0));
    checkOutput({name, "_err"},     word_t'(wmst_err),      word_t'(err_exp));
  endtask

  // Stream source and AXI ready patterns, updated at posedge+2.
  initial begin
    int   idx, gen, cyc;
    logic fire;
    idx = 0; gen = 0; cyc = 0;
    s_tvalid = 1'b0; s_tdata = '0; m_awready = 1'b0; m_wready = 1'b0;
    forever begin
      @(negedge clk);
      fire = s_tvalid && s_tready;
      @(posedge clk); #2;
      cyc++;
      if (src_gen != gen) begin
        gen = src_gen;
        idx = 0;
      end else if (fire) begin
        idx++;
      end
      s_tvalid  = (idx < src_words) && (cyc % 7 != 3);
      s_tdata   = mk_word(src_tid, idx);
      m_awready = (cyc % 4 != 1);
      m_wready  = (cyc % 5 != 2);
    end
  end

  // B responder: one response per completed burst, held off while b_hold.
  initial begin
    int   pend, nb, gen;
    logic wl, bf;
    pend = 0; nb = 0; gen = 0;
    m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      @(negedge clk);
      wl = m_wvalid && m_wready && m_wlast;
      bf = m_bvalid && m_bready;
      @(posedge clk); #2;
      if (!rst_n || src_gen != gen) begin
        gen = src_gen; pend = 0; nb = 0;
      end else begin
        if (bf) begin pend--; nb++; end
        if (wl) pend++;
      end
      m_bvalid = (pend > 0) && !b_hold;
      m_bresp  = (nb == err_burst) ? 2'b10 : AXI_RESP_OKAY;
    end
  end

  // Monitor: compares every AW and W handshake against the scoreboard.
  initial begin
    aw_t ea;
    w_t  ew;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_bvalid && m_bready) b_cnt++;
        if (m_awvalid && m_awready) begin
          aw_cnt++;
          if (exp_aw.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL aw_unexpected: got addr 0x%0h, none expected", m_awaddr);
          end else begin
            ea = exp_aw.pop_front();
            checkOutput("awaddr",  word_t'(m_awaddr),  word_t'(ea.addr));
            checkOutput("awlen",   word_t'(m_awlen),   word_t'(ea.len));
            checkOutput("awsize",  word_t'(m_awsize),  word_t'(6));
            checkOutput("awburst", word_t'(m_awburst), word_t'(1));
          end
          checkOutput("aw_outstanding_le4", word_t'((aw_cnt - b_cnt) <= 4), word_t'(1));
        end
        if (m_wvalid && m_wready) begin
          w_cnt++;
          checkOutput("w_after_aw", word_t'(aw_cnt > wlast_cnt), word_t'(1));
          if (exp_w.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL w_unexpected: got data 0x%0h, none expected", m_wdata[31:0]);
          end else begin
            ew = exp_w.pop_front();
            checkOutput("wdata", m_wdata, ew.data);
            checkOutput("wlast", word_t'(m_wlast), word_t'(ew.last));
            checkOutput("wstrb", word_t'(m_wstrb), word_t'({(DW/8){1'b1}}));
          end
          if (m_wlast) wlast_cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, aw0, w0;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; xfer_bytes = '0;
    b_hold = 1'b0; err_burst = -1; src_gen = 0; src_words = 0; src_tid = 0;
    flushScoreboard();
    repeat (2) @(posedge clk); #1;
    checkOutput("rst_awvalid", word_t'(m_awvalid), word_t'(0));
    checkOutput("rst_wvalid",  word_t'(m_wvalid),  word_t'(0));
    checkOutput("rst_tready",  word_t'(s_tready),  word_t'(0));
    checkOutput("rst_done",    word_t'(wmst_done), word_t'(0));
    checkOutput("rst_busy",    word_t'(wmst_busy), word_t'(0));
    checkOutput("rst_err",     word_t'(wmst_err),  word_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] 32 words from 0x1000");
    pushBurst(64'h1000, 15, 1, 0);
    pushBurst(64'h1400, 15, 1, 16);
    applyStimulus(1, 64'h1000, 32'd2048, 32);
    checkOutput("t1_busy_after_start", word_t'(wmst_busy), word_t'(1));
    waitDone("t1", 400);
    checkOutput("t1_bcount", word_t'(b_cnt), word_t'(2));
    checkOutput("t1_wlast_count", word_t'(wlast_cnt), word_t'(2));
    checkEnd("t1", 1'b0);
    flushScoreboard();

    $display("[TB] 1300 bytes -> 20 words");
    pushBurst(64'h2000, 15, 2, 0);
    pushBurst(64'h2400, 3, 2, 16);
    applyStimulus(2, 64'h2000, 32'd1300, 20);
    waitDone("t2", 400);
    checkOutput("t2_wcount", word_t'(w_cnt), word_t'(20));
    checkEnd("t2", 1'b0);
    flushScoreboard();

    $display("[TB] zero-length transfer");
    applyStimulus(3, 64'h8000, 32'd0, 0);
    checkOutput("t3_done_start_p1", word_t'(wmst_done), word_t'(0));
    checkOutput("t3_busy_start_p1", word_t'(wmst_busy), word_t'(1));
    @(posedge clk); #1;
    checkOutput("t3_done_start_p2", word_t'(wmst_done), word_t'(1));
    checkOutput("t3_busy_start_p2", word_t'(wmst_busy), word_t'(0));
    repeat (3) @(posedge clk); #1;
    checkOutput("t3_no_aw", word_t'(aw_cnt), word_t'(0));
    checkOutput("t3_done_held", word_t'(wmst_done), word_t'(1));
    flushScoreboard();

    $display("[TB] outstanding limit with B held");
    b_hold = 1'b1;
    for (int i = 0; i < 5; i++) pushBurst(64'h10000 + 64'(i) * 64'h400, 15, 4, 16 * i);
    applyStimulus(4, 64'h10000, 32'd5120, 80);
    aw0 = aw_cnt;
    repeat (300) @(posedge clk); #1;
    checkOutput("t4_aw_stalled_count", word_t'(aw_cnt - aw0), word_t'(4));
    checkOutput("t4_awvalid_stalled", word_t'(m_awvalid), word_t'(0));
    checkOutput("t4_not_done", word_t'(wmst_done), word_t'(0));
    b_hold = 1'b0;
    waitDone("t4", 600);
    checkOutput("t4_bcount", word_t'(b_cnt), word_t'(5));
    checkEnd("t4", 1'b0);
    flushScoreboard();

`ifdef ACC_WMST_4K_SPLIT_EN
    $display("[TB] 4KB split from 0x0F80");
    pushBurst(64'h0F80, 1, 5, 0);
    pushBurst(64'h1000, 13, 5, 2);
    applyStimulus(5, 64'h0F80, 32'd1024, 16);
    waitDone("t5", 400);
    checkEnd("t5", 1'b0);
    flushScoreboard();
`endif

    $display("[TB] error response on first burst");
    err_burst = 0;
    pushBurst(64'h3000, 15, 6, 0);
    pushBurst(64'h3400, 15, 6, 16);
    applyStimulus(6, 64'h3000, 32'd2048, 32);
    waitDone("t6", 400);
    checkEnd("t6", 1'b1);
    err_burst = -1;
    flushScoreboard();
    applyStimulus(7, 64'h0, 32'd0, 0);
    checkOutput("t6_err_cleared", word_t'(wmst_err), word_t'(0));
    checkOutput("t6_done_cleared", word_t'(wmst_done), word_t'(0));
    waitDone("t6b", 10);
    checkOutput("t6b_err", word_t'(wmst_err), word_t'(0));
    flushScoreboard();

    $display("[TB] reset during data phase");
    pushBurst(64'h5000, 15, 8, 0);
    applyStimulus(8, 64'h5000, 32'd1024, 16);
    w0 = w_cnt; n = 0;
    while ((w_cnt - w0) < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t7_reached_data", word_t'((w_cnt - w0) >= 3), word_t'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("t7_rst_awvalid", word_t'(m_awvalid), word_t'(0));
    checkOutput("t7_rst_wvalid",  word_t'(m_wvalid),  word_t'(0));
    checkOutput("t7_rst_tready",  word_t'(s_tready),  word_t'(0));
    checkOutput("t7_rst_busy",    word_t'(wmst_busy), word_t'(0));
    checkOutput("t7_rst_done",    word_t'(wmst_done), word_t'(0));
    checkOutput("t7_rst_err",     word_t'(wmst_err),  word_t'(0));
    flushScoreboard();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] transfer after reset");
    pushBurst(64'h6000, 15, 9, 0);
    applyStimulus(9, 64'h6000, 32'd1024, 16);
    waitDone("t8", 400);
    checkEnd("t8", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
